// File: rtl/configure_pkg.sv
// configure: shared memory request/response bus types
package configure;
  typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;
  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles both request ports and the merged memory bus
interface mem_arbiter_if;
  import configure::*;
  mem_in_type  imem_in, dmem_in, mem_in;
  mem_out_type imem_out, dmem_out, mem_out;
  modport master (output imem_in, dmem_in, mem_out, input imem_out, dmem_out, mem_in);
  modport slave (input imem_in, dmem_in, mem_out, output imem_out, dmem_out, mem_in);
endinterface

// File: rtl/mem_arbiter_buf.sv
// mem_arbiter_buf: one-entry request buffer, recaptures on the completing cycle
module mem_arbiter_buf
  import configure::*;
(
  input  logic       clk,
  input  logic       rst,
  input  mem_in_type req,
  input  logic       done,
  output mem_in_type q,
  output logic       nv
);
  typedef struct packed {
    logic        valid;
    logic        fence;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } buf_t;
  buf_t b;
  logic take;
  assign take = req.mem_valid && (!b.valid || done);
  assign nv = take || (b.valid && !done);
  assign q = '{mem_valid: b.valid, mem_fence: b.fence, mem_instr: b.instr,
               mem_addr: b.addr, mem_wdata: b.wdata, mem_wstrb: b.wstrb};
  always_ff @(posedge clk)
    if (!rst) b <= '0;
    else if (take) b <= '{valid: 1'b1, fence: req.mem_fence, instr: req.mem_instr,
                          addr: req.mem_addr, wdata: req.mem_wdata, wstrb: req.mem_wstrb};
    else if (done) b.valid <= 1'b0;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: merges instruction and data requests onto one memory bus
module mem_arbiter
  import configure::*;
#(
  parameter int arb_mode = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  output mem_in_type  mem_in,
  input  mem_out_type mem_out
);
  localparam logic [1:0] idle = 2'd0, busy_i = 2'd1, busy_d = 2'd2;
  logic [1:0] state, state_n;
  logic last_d, sel, pi, pd, tie_d, nv_i, nv_d;
  mem_in_type iq, dq;
  mem_arbiter_buf u_ibuf (.clk, .rst, .req(imem_in), .done(state == busy_i && mem_out.mem_ready), .q(iq), .nv(nv_i));
  mem_arbiter_buf u_dbuf (.clk, .rst, .req(dmem_in), .done(state == busy_d && mem_out.mem_ready), .q(dq), .nv(nv_d));
  // on completion the decision looks at next-cycle buffer contents so a handover has no bubble
  always_comb begin
    sel = state == idle || mem_out.mem_ready;
    pi = state == idle ? iq.mem_valid : nv_i;
    pd = state == idle ? dq.mem_valid : nv_d;
    tie_d = arb_mode != 0 || !last_d;
    state_n = !sel ? state : pd && (!pi || tie_d) ? busy_d : pi ? busy_i : idle;
  end
  // last_d remembers only tie outcomes
  always_ff @(posedge clk)
    if (!rst) begin
      state <= idle;
      last_d <= 1'b0;
    end else begin
      state <= state_n;
      if (sel && pi && pd) last_d <= state_n == busy_d;
    end
  assign mem_in = rst && state == busy_i ? iq : rst && state == busy_d ? dq : '0;
  assign imem_out = rst && state == busy_i ? mem_out : '0;
  assign dmem_out = rst && state == busy_d ? mem_out : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, routing, buffering and reset
module tb_mem_arbiter;
  import configure::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  mem_arbiter_if a ();
  mem_arbiter_if b ();
  mem_arbiter #(.arb_mode(0)) u0 (.clk(clk), .rst(rst), .imem_in(a.imem_in), .imem_out(a.imem_out),
    .dmem_in(a.dmem_in), .dmem_out(a.dmem_out), .mem_in(a.mem_in), .mem_out(a.mem_out));
  mem_arbiter #(.arb_mode(1)) u1 (.clk(clk), .rst(rst), .imem_in(b.imem_in), .imem_out(b.imem_out),
    .dmem_in(b.dmem_in), .dmem_out(b.dmem_out), .mem_in(b.mem_in), .mem_out(b.mem_out));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic mem_in_type rq(input logic instr, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    return '{mem_valid: 1'b1, mem_fence: 1'b0, mem_instr: instr, mem_addr: addr, mem_wdata: wdata, mem_wstrb: wstrb};
  endfunction
  task automatic do_reset();
    rst = 1'b0;
    a.imem_in = '0;
    a.dmem_in = '0;
    a.mem_out = '0;
    b.imem_in = '0;
    b.dmem_in = '0;
    b.mem_out = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask
  initial begin
    int k, dk, ig;
    do_reset();
    rst = 1'b0;
    a.dmem_in = rq(1'b0, 32'h10, 32'h0, 4'h0);
    a.mem_out = '{mem_ready: 1'b1, mem_rdata: 32'h5};
    #1;
    chk("rst_mem_valid", a.mem_in.mem_valid, 0);
    chk("rst_dmem_ready", a.dmem_out.mem_ready, 0);
    chk("rst_imem_rdata", a.imem_out.mem_rdata, 0);
    do_reset();
    a.dmem_in = rq(1'b0, 32'h80000010, 32'h0, 4'h0);
    #1 chk("t1_idle", a.mem_in.mem_valid, 0);
    @(negedge clk);
    #1 chk("t1_capture_idle", a.mem_in.mem_valid, 0);
    @(negedge clk);
    #1 chk("t1_valid", a.mem_in.mem_valid, 1);
    chk("t1_addr", a.mem_in.mem_addr, 32'h80000010);
    chk("t1_wait_ready0", a.dmem_out.mem_ready, 0);
    @(negedge clk);
    #1 chk("t1_wait_ready1", a.dmem_out.mem_ready, 0);
    chk("t1_imem_wait", a.imem_out.mem_ready, 0);
    @(negedge clk);
    a.mem_out = '{mem_ready: 1'b1, mem_rdata: 32'hDEADBEEF};
    a.dmem_in.mem_valid = 1'b0;
    #1 chk("t1_dready", a.dmem_out.mem_ready, 1);
    chk("t1_drdata", a.dmem_out.mem_rdata, 32'hDEADBEEF);
    chk("t1_iready", a.imem_out.mem_ready, 0);
    chk("t1_irdata", a.imem_out.mem_rdata, 0);
    @(negedge clk);
    a.mem_out = '{mem_ready: 1'b1, mem_rdata: 32'hCAFE};
    #1 chk("t1_after_valid", a.mem_in.mem_valid, 0);
    chk("t1_after_dready", a.dmem_out.mem_ready, 0);
    chk("t1_after_drdata", a.dmem_out.mem_rdata, 0);
    chk("t1_after_addr", a.mem_in.mem_addr, 0);
    do_reset();
    a.imem_in = rq(1'b1, 32'h100, 32'h0, 4'h0);
    a.dmem_in = rq(1'b0, 32'h200, 32'h0, 4'h0);
    @(negedge clk);
    #1 chk("t2_idle", a.mem_in.mem_valid, 0);
    @(negedge clk);
    #1 chk("t2_first_addr", a.mem_in.mem_addr, 32'h200);
    chk("t2_first_instr", a.mem_in.mem_instr, 0);
    a.mem_out = '{mem_ready: 1'b1, mem_rdata: 32'h11};
    a.dmem_in.mem_valid = 1'b0;
    #1 chk("t2_dready", a.dmem_out.mem_ready, 1);
    chk("t2_iready_off", a.imem_out.mem_ready, 0);
    @(negedge clk);
    a.mem_out = '0;
    #1 chk("t2_i_valid", a.mem_in.mem_valid, 1);
    chk("t2_i_addr", a.mem_in.mem_addr, 32'h100);
    chk("t2_i_instr", a.mem_in.mem_instr, 1);
    a.mem_out = '{mem_ready: 1'b1, mem_rdata: 32'h22};
    a.imem_in.mem_valid = 1'b0;
    #1 chk("t2_irdata", a.imem_out.mem_rdata, 32'h22);
    chk("t2_dready_off", a.dmem_out.mem_ready, 0);
    @(negedge clk);
    a.mem_out = '0;
    a.imem_in = rq(1'b1, 32'h300, 32'h0, 4'h0);
    a.dmem_in = rq(1'b0, 32'h400, 32'h0, 4'h0);
    #1 chk("t2_idle2", a.mem_in.mem_valid, 0);
    @(negedge clk);
    @(negedge clk);
    #1 chk("t2_tie2_instr", a.mem_in.mem_addr, 32'h300);
    a.mem_out.mem_ready = 1'b1;
    a.imem_in.mem_valid = 1'b0;
    @(negedge clk);
    a.mem_out = '0;
    #1 chk("t2_tie2_data", a.mem_in.mem_addr, 32'h400);
    a.mem_out.mem_ready = 1'b1;
    a.dmem_in.mem_valid = 1'b0;
    @(negedge clk);
    a.mem_out = '0;
    do_reset();
    a.dmem_in = rq(1'b0, 32'h0, 32'h0, 4'h0);
    k = 0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      a.mem_out = '0;
      #1;
      if (a.mem_in.mem_valid) begin
        chk("t3_addr", a.mem_in.mem_addr, 32'(k * 4));
        k++;
        a.mem_out.mem_ready = 1'b1;
        a.dmem_in.mem_addr = 32'(k * 4);
        if (k == 4) a.dmem_in.mem_valid = 1'b0;
      end
    end
    chk("t3_count", 32'(k), 4);
    do_reset();
    a.dmem_in = rq(1'b0, 32'h40, 32'h12345678, 4'h3);
    @(negedge clk);
    a.dmem_in.mem_wdata = 32'hFFFFFFFF;
    a.dmem_in.mem_wstrb = 4'hF;
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      #1 chk("t4_wstrb", a.mem_in.mem_wstrb, 4'h3);
      chk("t4_wdata", a.mem_in.mem_wdata, 32'h12345678);
      @(negedge clk);
    end
    a.mem_out.mem_ready = 1'b1;
    a.dmem_in.mem_valid = 1'b0;
    #1 chk("t4_ready_wstrb", a.mem_in.mem_wstrb, 4'h3);
    chk("t4_ready_wdata", a.mem_in.mem_wdata, 32'h12345678);
    @(negedge clk);
    a.mem_out = '0;
    do_reset();
    a.dmem_in = rq(1'b0, 32'h80, 32'h0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    #1 chk("t5_busy", a.mem_in.mem_valid, 1);
    rst = 1'b0;
    a.dmem_in.mem_valid = 1'b0;
    #1 chk("t5_rst_valid", a.mem_in.mem_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    a.mem_out = '{mem_ready: 1'b1, mem_rdata: 32'h99};
    #1 chk("t5_post_valid", a.mem_in.mem_valid, 0);
    chk("t5_late_dready", a.dmem_out.mem_ready, 0);
    chk("t5_late_iready", a.imem_out.mem_ready, 0);
    @(negedge clk);
    #1 chk("t5_late_dready2", a.dmem_out.mem_ready, 0);
    a.mem_out = '0;
    do_reset();
    b.imem_in = rq(1'b1, 32'h500, 32'h0, 4'h0);
    b.dmem_in = rq(1'b0, 32'h0, 32'h0, 4'h0);
    dk = 0;
    ig = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      b.mem_out = '0;
      #1;
      if (b.mem_in.mem_valid) begin
        b.mem_out.mem_ready = 1'b1;
        if (b.mem_in.mem_instr) begin
          chk("t6_instr_after_data", 32'(dk), 4);
          ig++;
          b.imem_in.mem_valid = 1'b0;
        end else begin
          chk("t6_addr", b.mem_in.mem_addr, 32'(dk * 4));
          dk++;
          b.dmem_in.mem_addr = 32'(dk * 4);
          if (dk == 4) b.dmem_in.mem_valid = 1'b0;
        end
      end
    end
    chk("t6_data_count", 32'(dk), 4);
    chk("t6_instr_count", 32'(ig), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter arb_mode, default 0, meaning 0 = round-robin and 1 = fixed data-port priority.
REQ-002 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port imem_in  input  mem_in_type  instruction request from the instruction TIM/cache.
REQ-005 SHALL have port imem_out  output  mem_out_type  instruction response (mem_ready, mem_rdata).
REQ-006 SHALL have port dmem_in  input  mem_in_type  data request from the data TIM.
REQ-007 SHALL have port dmem_out  output  mem_out_type  data response.
REQ-008 SHALL have port mem_in  output  mem_in_type  merged request to the memory bus.
REQ-009 SHALL have port mem_out  input  mem_out_type  memory bus response.

Function
REQ-010 SHALL hold one request buffer per port (valid, fence, instr, addr[31:0], wdata[31:0], wstrb[3:0]).
REQ-011 SHALL capture a port request when mem_valid=1 and that port's buffer is empty, or when that port receives mem_ready in the same cycle (back-to-back).
REQ-012 SHALL ignore mem_valid on a port whose request is buffered or outstanding and not completing, so a held valid is not duplicated.
REQ-013 SHALL run FSM states idle, busy_i, busy_d.
REQ-014 SHALL go idle -> busy_i or busy_d at the next edge when a buffer is pending, and set mem_in from the granted buffer one cycle after capture at the earliest.
REQ-015 SHALL keep mem_in.mem_valid=1 and all mem_in fields stable in busy_* until mem_out.mem_ready=1.
REQ-016 SHALL, on mem_ready in busy_*, clear the owner buffer (unless recaptured per REQ-011) and go to the next grant if the other buffer is pending, otherwise go idle, with no bubble cycle.
REQ-017 SHALL, when both buffers are pending, grant the port not granted last if arb_mode=0 (first tie after reset: data), or always data if arb_mode=1.
REQ-018 SHALL route mem_out.mem_ready and mem_rdata combinationally, same cycle, to the owner port only, with mem_ready=0 and mem_rdata=0 on the other port.
REQ-019 SHALL drive both port outputs as ready=0, rdata=0 in idle.
REQ-020 SHALL forward mem_fence and mem_instr unchanged from the granted buffer.
REQ-021 SHALL let fence requests arbitrate like any other request.
REQ-022 SHALL set mem_in.mem_valid=0 in idle, with all other mem_in fields 0.
REQ-023 SHALL leave both buffers unchanged when both ports capture in the same cycle as a completion, and apply the grant rule at the next decision.

Reset
REQ-024 SHALL, while rst=0, clear the state to idle, empty both buffers, clear last-grant to instruction, and drive all outputs 0.
REQ-025 SHALL drop any request outstanding when reset asserts mid-transfer, so that no ready is delivered to either port afterwards.

Structure
REQ-026 SHALL use the existing mem_in_type and mem_out_type from package configure.
REQ-027 SHALL declare its FSM state constants and buffer struct locally, with no new package.
REQ-028 SHALL instantiate one sub-module, mem_arbiter_buf, as a one-entry request buffer used twice.

Verification
REQ-029 SHALL cover: single data read, addr 0x80000010, mem_ready 2 cycles after mem_valid, rdata 0xDEADBEEF -> dmem_out ready=1 with rdata=0xDEADBEEF for one cycle, and imem_out.ready=0 throughout.
REQ-030 SHALL cover: imem and dmem valid in the same cycle with arb_mode=0 -> data served first, instruction issued in the cycle after data ready, and the next tie won by instruction.
REQ-031 SHALL cover: data port holds valid with addr incrementing by 4 on each ready over 4 words -> exactly 4 bus transactions with addrs 0x0,0x4,0x8,0xC and no duplicates.
REQ-032 SHALL cover: store wstrb=0x3, wdata=0x12345678 -> mem_in shows wstrb=0x3 and wdata=0x12345678, both stable until ready.
REQ-033 SHALL cover: rst=0 asserted while busy_d before ready -> next cycle mem_in.mem_valid=0, and a late mem_ready yields no port ready.
REQ-034 SHALL cover: arb_mode=1 with continuous data requests and one pending instruction request -> instruction not granted until the data buffer empties.
